// File: rtl/seg7_pkg.sv
// Shared definitions for the multiplexed 7-segment scan driver:
// segment ROM, blank pattern and index-width helper.
package seg7_pkg;

    // Segment order is {g,f,e,d,c,b,a}, active-high (1 = segment lit).
    localparam logic [6:0] SEG_BLANK = 7'h00;

    function automatic int unsigned idx_width(input int unsigned n);
        int unsigned w;
        w = 32'd1;
        for (int i = 0; i < 31; i++) begin
            if ((32'd1 << w) < n) begin
                w = w + 32'd1;
            end
        end
        return w;
    endfunction

    function automatic logic [6:0] seg_rom(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'h0:    pat = 7'h3F;
            4'h1:    pat = 7'h06;
            4'h2:    pat = 7'h5B;
            4'h3:    pat = 7'h4F;
            4'h4:    pat = 7'h66;
            4'h5:    pat = 7'h6D;
            4'h6:    pat = 7'h7D;
            4'h7:    pat = 7'h07;
            4'h8:    pat = 7'h7F;
            4'h9:    pat = 7'h6F;
            4'hA:    pat = 7'h77;
            4'hB:    pat = 7'h7C;
            4'hC:    pat = 7'h39;
            4'hD:    pat = 7'h5E;
            4'hE:    pat = 7'h79;
            4'hF:    pat = 7'h71;
            default: pat = SEG_BLANK;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational nibble-to-segment lookup with a forced-blank input.
// Output is active-high; polarity is applied by the caller's output register.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       blank,
    output logic [6:0] seg
);

    // Blank overrides the ROM pattern.
    always_comb begin
        seg = SEG_BLANK;
        if (blank) begin
            seg = SEG_BLANK;
        end else begin
            seg = seg_rom(nibble);
        end
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed 7-segment scan driver: tear-free frame latching, anti-ghost
// blanking, leading-zero suppression and per-digit blink.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS   = 3,
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYC    = 16,
    parameter int BLINK_FRAMES = 250,
    parameter int ACTIVE_LOW   = 1
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_ena,
    input  logic [4*NUM_DIGITS-1:0] i_digits,
    input  logic [NUM_DIGITS-1:0]   i_dp,
    input  logic                    i_load,
    input  logic                    i_blank_lz,
    input  logic [NUM_DIGITS-1:0]   i_blink,
    output logic [6:0]              o_seg,
    output logic                    o_dp,
    output logic [NUM_DIGITS-1:0]   o_an,
    output logic                    o_frame,
    output logic                    o_pending
);

    localparam int IDX_W = idx_width(NUM_DIGITS);
    localparam int PRE_W = idx_width(REFRESH_DIV);
    localparam int FRM_W = idx_width(BLINK_FRAMES);

    // XOR masks: an all-ones mask inverts to active-low at the output register.
    localparam logic                  POL     = (ACTIVE_LOW != 0);
    localparam logic [6:0]            SEG_OFF = {7{POL}};
    localparam logic [NUM_DIGITS-1:0] AN_OFF  = {NUM_DIGITS{POL}};

    logic [PRE_W-1:0]        presc_r;
    logic [IDX_W-1:0]        idx_r;
    logic [FRM_W-1:0]        frame_cnt_r;
    logic                    blink_phase_r;
    logic [4*NUM_DIGITS-1:0] pend_digits_r;
    logic [NUM_DIGITS-1:0]   pend_dp_r;
    logic                    pending_r;
    logic [4*NUM_DIGITS-1:0] disp_digits_r;
    logic [NUM_DIGITS-1:0]   disp_dp_r;
    logic [6:0]              seg_r;
    logic                    dp_r;
    logic [NUM_DIGITS-1:0]   an_r;
    logic                    frame_r;

    logic                    slot_end_s;
    logic                    wrap_s;
    logic [NUM_DIGITS-1:0]   lz_s;
    logic [3:0]              nib_s;
    logic                    dp_sel_s;
    logic                    lz_sel_s;
    logic                    blink_sel_s;
    logic [NUM_DIGITS-1:0]   an_sel_s;
    logic                    dark_s;
    logic [6:0]              seg_raw_s;

    assign slot_end_s = i_ena && (presc_r == PRE_W'(REFRESH_DIV - 1));
    assign wrap_s     = slot_end_s && (idx_r == IDX_W'(NUM_DIGITS - 1));

    // Slot prescaler and digit index.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            presc_r <= '0;
            idx_r   <= '0;
        end else if (slot_end_s) begin
            presc_r <= '0;
            idx_r   <= (idx_r == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_r + IDX_W'(1);
        end else if (i_ena) begin
            presc_r <= presc_r + PRE_W'(1);
        end
    end

    // Frame counter and blink phase advance once per completed frame.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            frame_cnt_r   <= '0;
            blink_phase_r <= 1'b0;
        end else if (wrap_s) begin
            if (frame_cnt_r == FRM_W'(BLINK_FRAMES - 1)) begin
                frame_cnt_r   <= '0;
                blink_phase_r <= ~blink_phase_r;
            end else begin
                frame_cnt_r <= frame_cnt_r + FRM_W'(1);
            end
        end
    end

    // Display takes the pending value as it stood before any load on the wrap
    // cycle, so a load that coincides with a wrap waits for the next frame.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            pend_digits_r <= '0;
            pend_dp_r     <= '0;
            pending_r     <= 1'b0;
            disp_digits_r <= '0;
            disp_dp_r     <= '0;
        end else begin
            if (wrap_s) begin
                disp_digits_r <= pend_digits_r;
                disp_dp_r     <= pend_dp_r;
            end
            if (i_load) begin
                pend_digits_r <= i_digits;
                pend_dp_r     <= i_dp;
                pending_r     <= 1'b1;
            end else if (wrap_s) begin
                pending_r <= 1'b0;
            end
        end
    end

    // Leading-zero map: digit k is suppressible when it and all higher digits are zero.
    always_comb begin
        logic higher_zero;
        higher_zero = 1'b1;
        lz_s        = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            higher_zero = higher_zero & (disp_digits_r[k*4 +: 4] == 4'h0);
            lz_s[k]     = (k != 0) && higher_zero;
        end
    end

    // Select the fields of the digit currently being scanned.
    always_comb begin
        nib_s       = 4'h0;
        dp_sel_s    = 1'b0;
        lz_sel_s    = 1'b0;
        blink_sel_s = 1'b0;
        an_sel_s    = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx_r == IDX_W'(k)) begin
                nib_s       = disp_digits_r[k*4 +: 4];
                dp_sel_s    = disp_dp_r[k];
                lz_sel_s    = lz_s[k];
                blink_sel_s = i_blink[k];
                an_sel_s[k] = 1'b1;
            end else begin
                an_sel_s[k] = 1'b0;
            end
        end
    end

    assign dark_s = blink_phase_r & blink_sel_s;

    seg7_decode u_decode (
        .nibble (nib_s),
        .blank  ((i_blank_lz & lz_sel_s) | dark_s),
        .seg    (seg_raw_s)
    );

    // Registered pin drive with polarity applied; anodes stay off in the blank window.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            seg_r   <= SEG_OFF;
            dp_r    <= POL;
            an_r    <= AN_OFF;
            frame_r <= 1'b0;
        end else if (!i_ena) begin
            seg_r   <= SEG_OFF;
            dp_r    <= POL;
            an_r    <= AN_OFF;
            frame_r <= 1'b0;
        end else begin
            seg_r   <= seg_raw_s ^ SEG_OFF;
            dp_r    <= (dp_sel_s & ~dark_s) ^ POL;
            an_r    <= (presc_r < PRE_W'(BLANK_CYC)) ? AN_OFF : (an_sel_s ^ AN_OFF);
            frame_r <= wrap_s;
        end
    end

    assign o_seg     = seg_r;
    assign o_dp      = dp_r;
    assign o_an      = an_r;
    assign o_frame   = frame_r;
    assign o_pending = pending_r;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver: directed steps plus random
// stimulus, compared every cycle against a time-based reference model.
module tb_seg7_scan_driver;

    localparam int ND   = 3;
    localparam int DIV  = 8;
    localparam int BLK  = 2;
    localparam int BF   = 2;
    localparam int FLEN = ND * DIV;

    logic            i_clk;
    logic            i_reset;
    logic            i_ena;
    logic [4*ND-1:0] i_digits;
    logic [ND-1:0]   i_dp;
    logic            i_load;
    logic            i_blank_lz;
    logic [ND-1:0]   i_blink;
    logic [6:0]      o_seg;
    logic            o_dp;
    logic [ND-1:0]   o_an;
    logic            o_frame;
    logic            o_pending;

    seg7_scan_driver #(
        .NUM_DIGITS   (ND),
        .REFRESH_DIV  (DIV),
        .BLANK_CYC    (BLK),
        .BLINK_FRAMES (BF),
        .ACTIVE_LOW   (1)
    ) dut (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_ena      (i_ena),
        .i_digits   (i_digits),
        .i_dp       (i_dp),
        .i_load     (i_load),
        .i_blank_lz (i_blank_lz),
        .i_blink    (i_blink),
        .o_seg      (o_seg),
        .o_dp       (o_dp),
        .o_an       (o_an),
        .o_frame    (o_frame),
        .o_pending  (o_pending)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int checks = 0;
    int errors = 0;

    // Reference model: t_m counts enabled cycles since reset; everything else
    // (slot, position, frame number, blink phase) is derived from it arithmetically.
    int            t_m;
    logic [11:0]   disp_m;
    logic [11:0]   pend_m;
    logic [ND-1:0] ddp_m;
    logic [ND-1:0] pdp_m;
    logic          pending_m;
    logic [6:0]    seg_tbl [16];

    task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h (t=%0d)", tag, obs, exp, t_m);
        end
    endtask

    task automatic tick();
        logic [ND-1:0] e_an;
        logic [6:0]    e_seg;
        logic          e_dp;
        logic          e_frame;
        logic          wrap;
        logic          off;
        logic [3:0]    nib;
        int            pre;
        int            idx;
        int            f;
        wrap = 1'b0;
        if (i_reset || !i_ena) begin
            e_an = 3'b111; e_seg = 7'h7F; e_dp = 1'b1; e_frame = 1'b0;
        end else begin
            pre  = t_m % DIV;
            idx  = (t_m / DIV) % ND;
            f    = t_m / FLEN;
            e_an = (pre < BLK) ? 3'b111 : ~(3'b001 << idx);
            nib  = 4'((disp_m >> (4 * idx)) & 12'h00F);
            off  = (((f / BF) % 2) == 1) && i_blink[idx];
            if (off || (i_blank_lz && idx > 0 && (disp_m >> (4 * idx)) == 12'h000))
                e_seg = 7'h7F;
            else
                e_seg = seg_tbl[nib];
            e_dp    = off ? 1'b1 : ~ddp_m[idx];
            wrap    = (t_m % FLEN) == (FLEN - 1);
            e_frame = wrap;
        end
        @(posedge i_clk);
        if (i_reset) begin
            t_m = 0; disp_m = '0; pend_m = '0; ddp_m = '0; pdp_m = '0; pending_m = 1'b0;
        end else begin
            if (wrap) begin
                disp_m = pend_m;
                ddp_m  = pdp_m;
            end
            if (i_load) begin
                pend_m = i_digits; pdp_m = i_dp; pending_m = 1'b1;
            end else if (wrap) begin
                pending_m = 1'b0;
            end
            if (i_ena) t_m++;
        end
        #1;
        check("an", 12'(o_an), 12'(e_an));
        check("seg", 12'(o_seg), 12'(e_seg));
        check("dp", 12'(o_dp), 12'(e_dp));
        check("frame", 12'(o_frame), 12'(e_frame));
        check("pending", 12'(o_pending), 12'(pending_m));
    endtask

    // Advance until the model sits at frame position ph (at least one cycle).
    task automatic run_until(input int ph);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while ((t_m % FLEN) != ph && n < 200);
        if ((t_m % FLEN) != ph) begin
            checks++;
            errors++;
            $error("FAIL run_until observed=%0d expected=%0d", t_m % FLEN, ph);
        end
    endtask

    task automatic load(input logic [11:0] d, input logic [ND-1:0] dp);
        i_digits = d; i_dp = dp; i_load = 1'b1;
        tick();
        i_load = 1'b0;
    endtask

    initial begin
        seg_tbl[0]  = 7'h40; seg_tbl[1]  = 7'h79; seg_tbl[2]  = 7'h24; seg_tbl[3]  = 7'h30;
        seg_tbl[4]  = 7'h19; seg_tbl[5]  = 7'h12; seg_tbl[6]  = 7'h02; seg_tbl[7]  = 7'h78;
        seg_tbl[8]  = 7'h00; seg_tbl[9]  = 7'h10; seg_tbl[10] = 7'h08; seg_tbl[11] = 7'h03;
        seg_tbl[12] = 7'h46; seg_tbl[13] = 7'h21; seg_tbl[14] = 7'h06; seg_tbl[15] = 7'h0E;
        t_m = 0; disp_m = '0; pend_m = '0; ddp_m = '0; pdp_m = '0; pending_m = 1'b0;
        i_reset = 1'b1; i_ena = 1'b0; i_digits = '0; i_dp = '0; i_load = 1'b0;
        i_blank_lz = 1'b0; i_blink = '0;

        repeat (3) tick();
        i_reset = 1'b0;
        i_ena   = 1'b1;

        // Basic scan with 159 applied at the first wrap.
        load(12'h159, 3'b000);
        run_until(FLEN - 1);
        run_until(3);
        check("d0_nine", 12'(o_seg), 12'(7'b0010000));
        check("d0_anode", 12'(o_an), 12'(3'b110));
        run_until(19);
        check("d2_one", 12'(o_seg), 12'(7'b1111001));
        check("d2_anode", 12'(o_an), 12'(3'b011));

        // Leading-zero suppression on and off.
        i_blank_lz = 1'b1;
        load(12'h007, 3'b001);
        run_until(FLEN - 1);
        run_until(19);
        check("lz_on_d2", 12'(o_seg), 12'(7'h7F));
        i_blank_lz = 1'b0;
        run_until(19);
        check("lz_off_d2", 12'(o_seg), 12'(7'b1000000));
        run_until(3);
        check("lz_d0_seven", 12'(o_seg), 12'(7'b1111000));

        // Mid-frame load does not tear the current frame.
        load(12'h059, 3'b000);
        run_until(FLEN - 1);
        run_until(12);
        load(12'h060, 3'b010);
        check("mid_pending", 12'(o_pending), 12'd1);
        run_until(FLEN - 1);
        check("mid_pending_hold", 12'(o_pending), 12'd1);
        tick();
        check("mid_frame", 12'(o_frame), 12'd1);
        check("mid_pending_clr", 12'(o_pending), 12'd0);

        // Load on the exact wrap cycle is applied one frame later.
        run_until(FLEN - 1);
        load(12'h3AF, 3'b100);
        check("wrap_frame", 12'(o_frame), 12'd1);
        check("wrap_pending", 12'(o_pending), 12'd1);
        run_until(FLEN - 1);
        tick();
        check("wrap_pending_clr", 12'(o_pending), 12'd0);

        // Blink digits 0 and 1 over several frames.
        i_blink = 3'b011;
        for (int i = 0; i < 8; i++) run_until(0);
        i_blink = 3'b000;

        // Random loads, enables, blink and suppression settings.
        for (int i = 0; i < 60; i++) begin
            i_blank_lz = 1'($urandom_range(0, 1));
            i_blink    = 3'($urandom_range(0, 7));
            i_ena      = ($urandom_range(0, 5) != 0);
            if ($urandom_range(0, 1) == 1)
                load(12'($urandom), 3'($urandom));
            repeat ($urandom_range(1, 30)) tick();
        end

        // Asynchronous reset mid-slot, then restart from digit 0, slot cycle 0.
        i_ena = 1'b1; i_blink = '0; i_blank_lz = 1'b0;
        run_until(5);
        #2;
        i_reset = 1'b1;
        #1;
        check("async_an", 12'(o_an), 12'(3'b111));
        check("async_seg", 12'(o_seg), 12'(7'h7F));
        repeat (2) tick();
        i_reset = 1'b0;
        repeat (2) tick();
        check("rst_blank2", 12'(o_an), 12'(3'b111));
        tick();
        check("rst_first_an", 12'(o_an), 12'(3'b110));
        repeat (30) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
